// File: rtl/lane_deskew.sv
// lane_deskew: two-lane receive deskew stage feeding data_bus_receive.
// Hunts for SYNC_BYTE on both raw lanes, measures how many cycles one lane
// leads the other, then delays the leading lane so that the bytes handed
// downstream are cycle-aligned.
//
// Ports
//   fsm_clk     single rising-edge clock
//   rst         synchronous active-low reset
//   lane_rx_on  receiver enable; low returns the block to IDLE
//   lane_0_rx   raw lane 0 byte, valid every cycle
//   lane_1_rx   raw lane 1 byte, valid every cycle
//   lane_0_al   deskewed lane 0 byte
//   lane_1_al   deskewed lane 1 byte
//   aligned     high while the outputs carry aligned data
//   skew_err    one-cycle pulse on skew overflow or alignment loss
//   skew_lane   lane being delayed (0 = lane 0, 1 = lane 1)
//   skew_cnt    applied delay in cycles
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | receiver off, outputs zero
// S_SEARCH  | looking for SYNC_BYTE on either lane
// S_WAIT    | sync seen on the early lane, counting until the late lane
// S_ALIGNED | delay applied, outputs carry deskewed data

module lane_deskew #(
  parameter logic [7:0] SYNC_BYTE = 8'hC5,
  parameter int         MAX_SKEW  = 7,
  parameter int         SKEW_W    = 4
) (
  input  logic              fsm_clk,
  input  logic              rst,
  input  logic              lane_rx_on,
  input  logic [7:0]        lane_0_rx,
  input  logic [7:0]        lane_1_rx,
  output logic [7:0]        lane_0_al,
  output logic [7:0]        lane_1_al,
  output logic              aligned,
  output logic              skew_err,
  output logic              skew_lane,
  output logic [SKEW_W-1:0] skew_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEARCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_ALIGNED = 2'd3
  } state_t;

  localparam logic [SKEW_W-1:0] MAX_C = SKEW_W'(MAX_SKEW);
  localparam logic [SKEW_W-1:0] ONE_C = SKEW_W'(1);

  state_t            state, state_nxt;
  logic [SKEW_W-1:0] cnt, cnt_nxt;
  logic              early, early_nxt;
  logic              skew_lane_nxt;
  logic [SKEW_W-1:0] skew_cnt_nxt;
  logic              err_nxt;
  logic [7:0]        lane_0_nxt, lane_1_nxt;
  logic              aligned_nxt;

  logic [7:0]        dly_0 [MAX_SKEW];
  logic [7:0]        dly_1 [MAX_SKEW];
  logic [SKEW_W-1:0] sel_0, sel_1;
  logic [7:0]        tap_0, tap_1;

  logic sync_0, sync_1, sync_other, sync_mine, out_sync_0, out_sync_1;

  assign sync_0     = (lane_0_rx == SYNC_BYTE);
  assign sync_1     = (lane_1_rx == SYNC_BYTE);
  assign sync_other = early ? sync_0 : sync_1;
  assign sync_mine  = early ? sync_1 : sync_0;
  assign out_sync_0 = (lane_0_al == SYNC_BYTE);
  assign out_sync_1 = (lane_1_al == SYNC_BYTE);

  always_ff @(posedge fsm_clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      early     <= 1'b0;
      skew_lane <= 1'b0;
      skew_cnt  <= '0;
      skew_err  <= 1'b0;
      aligned   <= 1'b0;
      lane_0_al <= '0;
      lane_1_al <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      early     <= early_nxt;
      skew_lane <= skew_lane_nxt;
      skew_cnt  <= skew_cnt_nxt;
      skew_err  <= err_nxt;
      aligned   <= aligned_nxt;
      lane_0_al <= lane_0_nxt;
      lane_1_al <= lane_1_nxt;
    end
  end

  // Delay lines run continuously; entry i holds the lane byte from i+1 cycles ago.
  always_ff @(posedge fsm_clk) begin
    if (!rst) begin
      for (int i = 0; i < MAX_SKEW; i++) begin
        dly_0[i] <= '0;
        dly_1[i] <= '0;
      end
    end else begin
      dly_0[0] <= lane_0_rx;
      dly_1[0] <= lane_1_rx;
      for (int i = 1; i < MAX_SKEW; i++) begin
        dly_0[i] <= dly_0[i-1];
        dly_1[i] <= dly_1[i-1];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    early_nxt     = early;
    skew_lane_nxt = skew_lane;
    skew_cnt_nxt  = skew_cnt;
    err_nxt       = 1'b0;
    if (!lane_rx_on) begin
      state_nxt    = S_IDLE;
      skew_cnt_nxt = '0;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_SEARCH;
        S_SEARCH: begin
          if (sync_0 && sync_1) begin
            skew_cnt_nxt = '0;
            state_nxt    = S_ALIGNED;
          end else if (sync_0 || sync_1) begin
            early_nxt     = sync_1;
            skew_lane_nxt = sync_1;
            cnt_nxt       = ONE_C;
            state_nxt     = S_WAIT;
          end
        end
        S_WAIT: begin
          // Overflow is tested before anything else so cnt never passes MAX_SKEW+1.
          if (cnt > MAX_C) begin
            err_nxt   = 1'b1;
            state_nxt = S_SEARCH;
          end else if (sync_0 && sync_1) begin
            skew_cnt_nxt = '0;
            state_nxt    = S_ALIGNED;
          end else if (sync_other) begin
            skew_cnt_nxt = cnt;
            state_nxt    = S_ALIGNED;
          end else if (sync_mine) begin
            cnt_nxt = ONE_C;
          end else begin
            cnt_nxt = cnt + ONE_C;
          end
        end
        S_ALIGNED: begin
          if (out_sync_0 != out_sync_1) begin
            err_nxt   = 1'b1;
            state_nxt = S_SEARCH;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Taps use the next-cycle skew so the sync pair lands on both outputs in
  // the very first ALIGNED cycle.
  assign sel_0 = skew_lane_nxt ? '0 : skew_cnt_nxt;
  assign sel_1 = skew_lane_nxt ? skew_cnt_nxt : '0;

  always_comb begin
    tap_0 = lane_0_rx;
    tap_1 = lane_1_rx;
    for (int i = 0; i < MAX_SKEW; i++) begin
      if (sel_0 == SKEW_W'(i + 1)) tap_0 = dly_0[i];
      if (sel_1 == SKEW_W'(i + 1)) tap_1 = dly_1[i];
    end
  end

  always_comb begin
    lane_0_nxt  = '0;
    lane_1_nxt  = '0;
    aligned_nxt = 1'b0;
    if (state_nxt == S_ALIGNED) begin
      lane_0_nxt  = tap_0;
      lane_1_nxt  = tap_1;
      aligned_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_lane_deskew.sv
module tb_lane_deskew;

  logic       fsm_clk = 1'b0;
  logic       rst = 1'b0;
  logic       lane_rx_on = 1'b0;
  logic [7:0] lane_0_rx = 8'h00;
  logic [7:0] lane_1_rx = 8'h00;
  logic [7:0] lane_0_al, lane_1_al;
  logic       aligned, skew_err, skew_lane;
  logic [3:0] skew_cnt;

  int total = 0;
  int bad = 0;

  localparam logic [7:0] SY = 8'hC5;

  lane_deskew #(.SYNC_BYTE(8'hC5), .MAX_SKEW(7), .SKEW_W(4)) dut (
    .fsm_clk(fsm_clk), .rst(rst), .lane_rx_on(lane_rx_on),
    .lane_0_rx(lane_0_rx), .lane_1_rx(lane_1_rx),
    .lane_0_al(lane_0_al), .lane_1_al(lane_1_al),
    .aligned(aligned), .skew_err(skew_err),
    .skew_lane(skew_lane), .skew_cnt(skew_cnt)
  );

  always #5 fsm_clk = ~fsm_clk;

  task automatic cyc(input logic [7:0] b0, input logic [7:0] b1);
    lane_0_rx = b0;
    lane_1_rx = b1;
    @(posedge fsm_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic ea, input logic ee);
    chk({tag, ".lane_0_al"}, {24'd0, lane_0_al}, {24'd0, e0});
    chk({tag, ".lane_1_al"}, {24'd0, lane_1_al}, {24'd0, e1});
    chk({tag, ".aligned"}, {31'd0, aligned}, {31'd0, ea});
    chk({tag, ".skew_err"}, {31'd0, skew_err}, {31'd0, ee});
  endtask

  initial begin
    // Reset with random non-sync traffic (top bit cleared, so never 8'hC5).
    rst = 1'b0;
    lane_rx_on = 1'b1;
    for (int i = 0; i < 2; i++) cyc(8'($urandom) & 8'h7F, 8'($urandom) & 8'h7F);
    chk_out("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    chk("reset.skew_cnt", {28'd0, skew_cnt}, 32'd0);
    chk("reset.skew_lane", {31'd0, skew_lane}, 32'd0);

    rst = 1'b1;
    cyc(8'h00, 8'h00);                       // IDLE -> SEARCH
    chk_out("search", 8'h00, 8'h00, 1'b0, 1'b0);

    // Zero skew
    cyc(SY, SY);
    chk_out("zs.sync", SY, SY, 1'b1, 1'b0);
    chk("zs.skew_cnt", {28'd0, skew_cnt}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc(8'(k), 8'(k));
      chk_out("zs.data", 8'(k), 8'(k), 1'b1, 1'b0);
    end

    // Disable while aligned
    lane_rx_on = 1'b0;
    cyc(8'h06, 8'h06);
    chk_out("dis", 8'h00, 8'h00, 1'b0, 1'b0);
    chk("dis.skew_cnt", {28'd0, skew_cnt}, 32'd0);
    lane_rx_on = 1'b1;
    cyc(8'h00, 8'h00);                       // IDLE -> SEARCH

    // Skew 3, lane 0 early
    cyc(SY, 8'h00);
    cyc(8'h01, 8'h00);
    cyc(8'h02, 8'h00);
    chk_out("sk3.wait", 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h03, SY);
    chk_out("sk3.sync", SY, SY, 1'b1, 1'b0);
    chk("sk3.skew_cnt", {28'd0, skew_cnt}, 32'd3);
    chk("sk3.skew_lane", {31'd0, skew_lane}, 32'd0);
    cyc(8'h04, 8'h01);
    chk_out("sk3.d1", 8'h01, 8'h01, 1'b1, 1'b0);
    cyc(8'h05, 8'h02);
    chk_out("sk3.d2", 8'h02, 8'h02, 1'b1, 1'b0);
    cyc(8'h06, 8'h03);
    chk_out("sk3.d3", 8'h03, 8'h03, 1'b1, 1'b0);

    // Loss: lone sync on lane 0 reaches lane_0_al four edges later
    cyc(SY, 8'h04);
    chk_out("loss.d4", 8'h04, 8'h04, 1'b1, 1'b0);
    cyc(8'h07, 8'h05);
    cyc(8'h08, 8'h06);
    cyc(8'h09, 8'h07);
    chk_out("loss.lone", SY, 8'h07, 1'b1, 1'b0);
    cyc(8'h0A, 8'h08);
    chk_out("loss.err", 8'h00, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 8'h00);
    chk_out("loss.search", 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(SY, SY);
    chk_out("loss.realign", SY, SY, 1'b1, 1'b0);
    chk("loss.skew_cnt", {28'd0, skew_cnt}, 32'd0);
    cyc(8'h11, 8'h11);
    chk_out("loss.data", 8'h11, 8'h11, 1'b1, 1'b0);

    // Max skew: lane 1 leads by 7
    lane_rx_on = 1'b0;
    cyc(8'h00, 8'h00);
    lane_rx_on = 1'b1;
    cyc(8'h00, 8'h00);
    cyc(8'h00, SY);
    for (int k = 1; k <= 6; k++) cyc(8'h00, 8'(k));
    chk_out("max.wait", 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(SY, 8'h07);
    chk_out("max.sync", SY, SY, 1'b1, 1'b0);
    chk("max.skew_cnt", {28'd0, skew_cnt}, 32'd7);
    chk("max.skew_lane", {31'd0, skew_lane}, 32'd1);
    cyc(8'h01, 8'h08);
    chk_out("max.d1", 8'h01, 8'h01, 1'b1, 1'b0);
    cyc(8'h02, 8'h09);
    chk_out("max.d2", 8'h02, 8'h02, 1'b1, 1'b0);

    // Overflow: lane 1 leads by 8
    lane_rx_on = 1'b0;
    cyc(8'h00, 8'h00);
    lane_rx_on = 1'b1;
    cyc(8'h00, 8'h00);
    cyc(8'h00, SY);
    for (int k = 1; k <= 7; k++) cyc(8'h00, 8'(k));
    chk_out("ovf.wait", 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(SY, 8'h08);
    chk_out("ovf.err", 8'h00, 8'h00, 1'b0, 1'b1);
    chk("ovf.skew_cnt", {28'd0, skew_cnt}, 32'd0);
    cyc(8'h00, 8'h09);
    chk_out("ovf.after", 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(SY, SY);
    chk_out("ovf.realign", SY, SY, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
